// File: rtl/cpc_clk_pkg.sv
// Shared constants for the CPC clock-enable generator: phase decode points and PHI phase masks.
package cpc_clk_pkg;

  localparam logic [3:0] PH_CCLK_P      = 4'd15;
  localparam logic [3:0] PH_CCLK_N      = 4'd7;
  localparam logic [3:0] PH_MODE_SAMPLE = 4'd15;

  // Bit n set means the enable fires when phase == n.
  localparam logic [15:0] MASK_PHI_P_NORM = 16'h8888;
  localparam logic [15:0] MASK_PHI_N_NORM = 16'h2222;
  localparam logic [15:0] MASK_PHI_P_FAST = 16'hAAAA;
  localparam logic [15:0] MASK_PHI_N_FAST = 16'h5555;

  function automatic logic phase_hit(input logic [15:0] mask, input logic [3:0] phase);
    return mask[phase];
  endfunction

endpackage

// File: rtl/cpc_cen_tick.sv
// Base 16 MHz tick generator: integer divider, or fractional phase accumulator when
// CPC_CEN_FRAC_DIV_EN is defined.
module cpc_cen_tick #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned FRAC_NUM = 1,
  parameter int unsigned FRAC_DEN = 4
) (
  input  logic clk,
  input  logic reset,
  output logic cen_16,
  output logic clk_16
);

  // Reject divider settings that cannot give a clean half-period split.
  if (CLK_DIV < 2 || (CLK_DIV % 2) != 0 || 2 * FRAC_NUM > FRAC_DEN) begin : g_bad_params
    $error("cpc_cen_tick: illegal divider parameters");
  end

  logic cen_q;
  logic clk16_q;
  logic tick;

`ifdef CPC_CEN_FRAC_DIV_EN
  localparam int unsigned AW = $clog2(FRAC_DEN) + 1;
  localparam logic [AW:0]   NUM  = (AW + 1)'(FRAC_NUM);
  localparam logic [AW:0]   DEN  = (AW + 1)'(FRAC_DEN);
  localparam logic [AW-1:0] HALF = AW'(FRAC_DEN / 2);

  logic [AW-1:0] acc_q, acc_d;
  logic [AW:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + NUM;
    tick  = (sum >= DEN);
    acc_d = tick ? AW'(sum - DEN) : sum[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q   <= '0;
      cen_q   <= 1'b0;
      clk16_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cen_q   <= tick;
      clk16_q <= (acc_q < HALF);
    end
  end
`else
  localparam int unsigned CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] HALF    = CW'(CLK_DIV / 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      cen_q   <= 1'b0;
      clk16_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      cen_q   <= tick;
      clk16_q <= (cnt_q < HALF);
    end
  end
`endif

  assign cen_16 = cen_q;
  assign clk_16 = clk16_q;

endmodule

// File: rtl/cpc_cen_gen.sv
// CPC clock-enable generator: 16-phase sequencer with PHI/CCLK edge enables and turbo mode.
// Fractional tick division is selected with CPC_CEN_FRAC_DIV_EN.
module cpc_cen_gen
  import cpc_clk_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned FRAC_NUM = 1,
  parameter int unsigned FRAC_DEN = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       fast,
  input  logic       resync,
  output logic       cen_16,
  output logic       clk_16,
  output logic [3:0] phase,
  output logic       phi_n,
  output logic       phi_en_p,
  output logic       phi_en_n,
  output logic       cclk_en_p,
  output logic       cclk_en_n,
  output logic       fast_act
);

  logic [3:0] phase_q, phase_d;
  logic       fast_act_q, fast_act_d;
  logic       phi_n_q, phi_n_d;

  cpc_cen_tick #(
    .CLK_DIV  (CLK_DIV),
    .FRAC_NUM (FRAC_NUM),
    .FRAC_DEN (FRAC_DEN)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .cen_16 (cen_16),
    .clk_16 (clk_16)
  );

  always_comb begin
    phi_en_p  = cen_16 & phase_hit(fast_act_q ? MASK_PHI_P_FAST : MASK_PHI_P_NORM, phase_q);
    phi_en_n  = cen_16 & phase_hit(fast_act_q ? MASK_PHI_N_FAST : MASK_PHI_N_NORM, phase_q);
    cclk_en_p = cen_16 & (phase_q == PH_CCLK_P);
    cclk_en_n = cen_16 & (phase_q == PH_CCLK_N);

    phase_d    = phase_q;
    fast_act_d = fast_act_q;
    phi_n_d    = phi_n_q;
    if (cen_16) begin
      phase_d = resync ? 4'd0 : phase_q + 4'd1;
      // Mode only changes at the period boundary so no PHI half-period gets truncated.
      if (phase_q == PH_MODE_SAMPLE) fast_act_d = fast;
    end
    if (phi_en_p)      phi_n_d = 1'b0;
    else if (phi_en_n) phi_n_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= 4'd0;
      fast_act_q <= 1'b0;
      phi_n_q    <= 1'b1;
    end else begin
      phase_q    <= phase_d;
      fast_act_q <= fast_act_d;
      phi_n_q    <= phi_n_d;
    end
  end

  assign phase    = phase_q;
  assign fast_act = fast_act_q;
  assign phi_n    = phi_n_q;

endmodule
